// File: rtl/crop_window_ctrl.sv
// Dark-object crop sequencer: measures the bounding box of dark pixels in a search ROI, then gates the stream.
// Build option: CROP_CTRL_CONT_EN re-measures and re-latches the window on every CROP frame.
module crop_window_ctrl #(
    parameter int DATA_W = 10,
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int ROI_X0 = 160,
    parameter int ROI_X1 = 480,
    parameter int ROI_Y0 = 10,
    parameter int ROI_Y1 = 470,
    parameter int THRESH = 0
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic              iSTART,
    input  logic              iSTOP,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic [15:0]       oXSTART,
    output logic [15:0]       oXEND,
    output logic [15:0]       oYSTART,
    output logic [15:0]       oYEND,
    output logic              oWIN_VALID,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [1:0]        oSTATE
);
    // Stream is valid-only (no ready): each cycle with iDVAL high carries exactly one pixel,
    // the pixel is always accepted, and oDATA/oDVAL follow one cycle later.

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SOF = 2'd1, MEASURE = 2'd2, CROP = 2'd3} state_t;

    localparam logic [15:0]       X_LAST = 16'(H_ACT - 1);
    localparam logic [15:0]       Y_LAST = 16'(V_ACT - 1);
    localparam logic [15:0]       MIN_X_INIT = 16'(H_ACT);
    localparam logic [15:0]       MIN_Y_INIT = 16'(V_ACT);
    localparam logic [DATA_W-1:0] THR = DATA_W'(THRESH);

    state_t      state, nextState;
    logic [15:0] xCnt, yCnt;
    logic [15:0] minX, maxX, minY, maxY;
    logic [15:0] nMinX, nMaxX, nMinY, nMaxY;
    logic        found, nFound, stopPend;
    logic        sof, eof, inRoi, hit, inWin;
    logic        measuring, latchEn, gating;

    assign sof   = iDVAL && (xCnt == 16'd0) && (yCnt == 16'd0);
    assign eof   = iDVAL && (xCnt == X_LAST) && (yCnt == Y_LAST);
    assign inRoi = (xCnt > 16'(ROI_X0)) && (xCnt < 16'(ROI_X1)) &&
                   (yCnt > 16'(ROI_Y0)) && (yCnt < 16'(ROI_Y1));
    assign hit   = iDVAL && measuring && (iDATA <= THR) && inRoi;
    assign inWin = (xCnt >= oXSTART) && (xCnt <= oXEND) && (yCnt >= oYSTART) && (yCnt <= oYEND);

    // Box including the current pixel, so the EOF pixel still counts when latching.
    assign nMinX  = (hit && xCnt < minX) ? xCnt : minX;
    assign nMaxX  = (hit && xCnt > maxX) ? xCnt : maxX;
    assign nMinY  = (hit && yCnt < minY) ? yCnt : minY;
    assign nMaxY  = (hit && yCnt > maxY) ? yCnt : maxY;
    assign nFound = found | hit;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (iDVAL) begin
            if (xCnt == X_LAST) begin
                xCnt <= '0;
                yCnt <= (yCnt == Y_LAST) ? 16'd0 : yCnt + 16'd1;
            end else begin
                xCnt <= xCnt + 16'd1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (iSTART && !iSTOP) nextState = WAIT_SOF;
            WAIT_SOF: if (sof) nextState = MEASURE;
            MEASURE:  if (eof) nextState = nFound ? CROP : IDLE;
            CROP:     if (eof && (stopPend || iSTOP)) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_comb begin
        oBUSY     = (state != IDLE);
        gating    = (state == CROP);
`ifdef CROP_CTRL_CONT_EN
        measuring = (state == MEASURE) || (state == CROP) || (state == WAIT_SOF && sof);
        latchEn   = eof && ((state == MEASURE) || (state == CROP));
`else
        measuring = (state == MEASURE) || (state == WAIT_SOF && sof);
        latchEn   = eof && (state == MEASURE);
`endif
    end

    assign oSTATE = state;

    // Running box is cleared after every measured EOF so the next measured frame starts clean.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            minX <= MIN_X_INIT;
            maxX <= '0;
            minY <= MIN_Y_INIT;
            maxY <= '0;
            found <= 1'b0;
        end else if (eof && measuring) begin
            minX <= MIN_X_INIT;
            maxX <= '0;
            minY <= MIN_Y_INIT;
            maxY <= '0;
            found <= 1'b0;
        end else begin
            minX <= nMinX;
            maxX <= nMaxX;
            minY <= nMinY;
            maxY <= nMaxY;
            found <= nFound;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oXSTART    <= '0;
            oXEND      <= '0;
            oYSTART    <= '0;
            oYEND      <= '0;
            oWIN_VALID <= 1'b0;
            oDONE      <= 1'b0;
        end else begin
            oDONE <= latchEn;
            if (latchEn) begin
                if (nFound) begin
                    oXSTART    <= nMinX;
                    oXEND      <= nMaxX;
                    oYSTART    <= nMinY;
                    oYEND      <= nMaxY;
                    oWIN_VALID <= 1'b1;
                end else if (state == MEASURE) begin
                    oWIN_VALID <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            stopPend <= 1'b0;
        end else if (state == CROP) begin
            if (eof && (stopPend || iSTOP)) stopPend <= 1'b0;
            else if (iSTOP)                 stopPend <= 1'b1;
        end else begin
            stopPend <= 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDATA <= '0;
            oDVAL <= 1'b0;
        end else begin
            oDATA <= iDATA;
            oDVAL <= iDVAL && (!gating || inWin);
        end
    end

endmodule

// File: tb/tb_crop_window_ctrl.sv
// Directed bench for crop_window_ctrl on a reduced 40x30 frame; expectations adapt to CROP_CTRL_CONT_EN.
module tb_crop_window_ctrl;
    localparam int H = 40;
    localparam int V = 30;
`ifdef CROP_CTRL_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic [9:0]  iDATA = '0;
    logic        iDVAL = 1'b0;
    logic        iSTART = 1'b0;
    logic        iSTOP = 1'b0;
    logic [9:0]  oDATA;
    logic        oDVAL;
    logic [15:0] oXSTART, oXEND, oYSTART, oYEND;
    logic        oWIN_VALID, oBUSY, oDONE;
    logic [1:0]  oSTATE;

    crop_window_ctrl #(
        .DATA_W(10), .H_ACT(H), .V_ACT(V),
        .ROI_X0(8), .ROI_X1(30), .ROI_Y0(2), .ROI_Y1(27), .THRESH(0)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL),
        .iSTART(iSTART), .iSTOP(iSTOP), .oDATA(oDATA), .oDVAL(oDVAL),
        .oXSTART(oXSTART), .oXEND(oXEND), .oYSTART(oYSTART), .oYEND(oYEND),
        .oWIN_VALID(oWIN_VALID), .oBUSY(oBUSY), .oDONE(oDONE), .oSTATE(oSTATE)
    );

    always #5 iCLK = ~iCLK;

    int vecs = 0;
    int fails = 0;
    int dvalCnt = 0;
    int doneCnt = 0;
    int gapViol = 0;
    int dataViol = 0;
    logic       dvalD = 1'b0;
    logic [9:0] dataD = '0;

    // Image model: one dark rectangle, or a set of dark points that all sit outside the ROI.
    bit outMode = 1'b0;
    int bx0 = 100, bx1 = 0, by0 = 100, by1 = 0;

    function automatic logic [9:0] pix(int x, int y);
        if (outMode)
            return ((x == 8 && y == 10) || (x == 30 && y == 15) || (x == 20 && y == 2) ||
                    (x == 20 && y == 27) || (x == 5 && y == 5)) ? 10'd0 : 10'd1023;
        return (x >= bx0 && x <= bx1 && y >= by0 && y <= by1) ? 10'd0 : 10'd1023;
    endfunction

    always @(posedge iCLK) begin
        dvalD <= iDVAL;
        dataD <= iDATA;
    end

    always @(negedge iCLK) begin
        if (iRST) begin
            if (oDVAL) dvalCnt++;
            if (oDONE) doneCnt++;
            if (oDVAL && !dvalD) gapViol++;
            if (oDVAL && oDATA !== dataD) dataViol++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            iDVAL = 1'b0; iSTART = 1'b0; iSTOP = 1'b0;
            @(posedge iCLK); #1;
        end
    endtask

    task automatic pulse(input bit st, input bit sp);
        iDVAL = 1'b0; iSTART = st; iSTOP = sp;
        @(posedge iCLK); #1;
        iSTART = 1'b0; iSTOP = 1'b0;
    endtask

    // Drives pixels 0..nPix-1 of a frame; gapPct inserts idle cycles, stopAt pulses iSTOP on that pixel.
    task automatic send_frame(input int gapPct, input int stopAt, input int nPix);
        for (int i = 0; i < nPix; i++) begin
            if (gapPct > 0)
                while ($urandom_range(0, 99) < gapPct) idle(1);
            iDVAL = 1'b1;
            iDATA = pix(i % H, i / H);
            iSTOP = (i == stopAt);
            @(posedge iCLK); #1;
        end
        idle(3);
    endtask

    task automatic check_win(input string tag, input int xs, input int xe, input int ys, input int ye);
        check({tag, "_xstart"}, int'(oXSTART), xs);
        check({tag, "_xend"}, int'(oXEND), xe);
        check({tag, "_ystart"}, int'(oYSTART), ys);
        check({tag, "_yend"}, int'(oYEND), ye);
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_dval", int'(oDVAL), 0);
        check("rst_done", int'(oDONE), 0);
        check("rst_busy", int'(oBUSY), 0);
        check("rst_winvalid", int'(oWIN_VALID), 0);
        check_win("rst", 0, 0, 0, 0);
        iRST = 1'b1;
        idle(2);

        // Async reset in the middle of a measured frame
        pulse(1'b1, 1'b0);
        check("wait_sof_state", int'(oSTATE), 1);
        send_frame(0, -1, 100);
        check("midframe_busy", int'(oBUSY), 1);
        check("midframe_state", int'(oSTATE), 2);
        iDVAL = 1'b1; iDATA = 10'h155;
        @(posedge iCLK); #2;
        iRST = 1'b0;
        #1;
        check("async_rst_busy", int'(oBUSY), 0);
        check("async_rst_dval", int'(oDVAL), 0);
        check("async_rst_data", int'(oDATA), 0);
        iDVAL = 1'b0;
        idle(2);
        iRST = 1'b1;
        idle(2);

        // Passthrough after reset
        dvalCnt = 0; doneCnt = 0;
        send_frame(0, -1, H * V);
        check("pass_dval_cnt", dvalCnt, H * V);
        check("pass_done_cnt", doneCnt, 0);

        // Dark pixels only outside the ROI (strict bounds)
        outMode = 1'b1;
        pulse(1'b1, 1'b0);
        dvalCnt = 0; doneCnt = 0;
        send_frame(0, -1, H * V);
        check("out_done_cnt", doneCnt, 1);
        check("out_winvalid", int'(oWIN_VALID), 0);
        check("out_busy", int'(oBUSY), 0);
        check("out_dval_cnt", dvalCnt, H * V);
        check_win("out", 0, 0, 0, 0);
        dvalCnt = 0;
        send_frame(0, -1, H * V);
        check("out_nogate_cnt", dvalCnt, H * V);

        // Simultaneous start and stop: stop wins
        outMode = 1'b0;
        pulse(1'b1, 1'b1);
        check("startstop_busy", int'(oBUSY), 0);
        dvalCnt = 0; doneCnt = 0;
        send_frame(0, -1, H * V);
        check("startstop_done", doneCnt, 0);
        check("startstop_cnt", dvalCnt, H * V);

        // Single dark block X=10..15, Y=5..9
        bx0 = 10; bx1 = 15; by0 = 5; by1 = 9;
        pulse(1'b1, 1'b0);
        dvalCnt = 0; doneCnt = 0;
        send_frame(0, -1, H * V);
        check("f1_dval_cnt", dvalCnt, H * V);
        check("f1_done", doneCnt, 1);
        check_win("f1", 10, 15, 5, 9);
        check("f1_winvalid", int'(oWIN_VALID), 1);
        check("f1_state", int'(oSTATE), 3);
        dvalCnt = 0; doneCnt = 0;
        send_frame(0, -1, H * V);
        check("f2_gated_cnt", dvalCnt, 30);
        check("f2_done", doneCnt, CONT ? 1 : 0);

        // Block moves to X=20..23; frame 4 is all bright
        bx0 = 20; bx1 = 23;
        dvalCnt = 0;
        send_frame(0, -1, H * V);
        check("f3_gated_cnt", dvalCnt, 30);
        check_win("f3", CONT ? 20 : 10, CONT ? 23 : 15, 5, 9);
        bx0 = 100; bx1 = 0;
        dvalCnt = 0; doneCnt = 0;
        send_frame(0, -1, H * V);
        check("f4_gated_cnt", dvalCnt, CONT ? 20 : 30);
        check("f4_done", doneCnt, CONT ? 1 : 0);
        check("f4_winvalid", int'(oWIN_VALID), 1);
        check_win("f4", CONT ? 20 : 10, CONT ? 23 : 15, 5, 9);

        // Stop mid-frame: gating runs to EOF, then full passthrough
        dvalCnt = 0;
        send_frame(0, 600, H * V);
        check("stop_gated_cnt", dvalCnt, CONT ? 20 : 30);
        check("stop_busy", int'(oBUSY), 0);
        dvalCnt = 0;
        send_frame(0, -1, H * V);
        check("after_stop_cnt", dvalCnt, H * V);
        check("win_held_xstart", int'(oXSTART), CONT ? 20 : 10);

        // Measurement with 30% idle gaps, block X=12..17, Y=6..11
        bx0 = 12; bx1 = 17; by0 = 6; by1 = 11;
        pulse(1'b1, 1'b0);
        doneCnt = 0;
        send_frame(30, -1, H * V);
        check_win("gap", 12, 17, 6, 11);
        check("gap_winvalid", int'(oWIN_VALID), 1);
        check("gap_done", doneCnt, 1);
        dvalCnt = 0;
        send_frame(30, 300, H * V);
        check("gap_gated_cnt", dvalCnt, 36);
        check("gap_stop_busy", int'(oBUSY), 0);
        check("dval_in_gap", gapViol, 0);
        check("data_path", dataViol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
